// File: rtl/res_station_param.sv
// res_station_param: reservation station for one functional-unit group.
// Holds up to DEPTH dispatched ops. Operands arrive as values or producer tags,
// pending tags are resolved by snooping the CDB, and the oldest fully-ready
// entry is offered to the FU over a valid/ready handshake.
//
// Ports:
//   clk, nRST                      clock (rising edge), synchronous active-low reset
//   flush                          clears every entry (mispredict recovery)
//   disp_valid / disp_ready        dispatch handshake; disp_ready = !full
//   disp_op, disp_vj/vk, disp_qj/qk  dispatched opcode, operand values, producer tags (0 = value valid)
//   cdb_valid, cdb_tag, cdb_data   common data bus broadcast
//   issue_valid / issue_ready      issue handshake towards the FU
//   issue_op, issue_vj/vk          presented opcode and operands (0 when nothing is presented)
//   issue_tag                      {zero pad, STATION_ID, entry index}, the result tag for the CDB
//   full, count                    occupancy status
module res_station_param #(
    parameter int unsigned  DEPTH      = 4,
    parameter int unsigned  DATA_W     = 32,
    parameter int unsigned  OP_W       = 5,
    parameter int unsigned  TAG_W      = 4,
    parameter int unsigned  ID_W       = 2,
    parameter int unsigned  STATION_ID = 1,
    localparam int unsigned IDX_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_vj,
    output logic [DATA_W-1:0] issue_vk,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    // Entry storage
    logic [DEPTH-1:0]  busy_q, busy_d;
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]  age_q [DEPTH];
    logic [DEPTH-1:0]  age_d [DEPTH];
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [OP_W-1:0]   op_d  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vj_d  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [DATA_W-1:0] vk_d  [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qj_d  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [TAG_W-1:0]  qk_d  [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DEPTH-1:0]  ready_c;
    logic [DEPTH-1:0]  blocked_c;
    logic              sel_valid_c;
    logic [IDX_W-1:0]  sel_idx_c;
    logic [IDX_W-1:0]  alloc_idx_c;
    logic              full_c;
    logic              disp_fire_c;
    logic              issue_fire_c;
    logic              cdb_live_c;

    // Ready entries, judged from registered state only
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_c[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    // An entry is blocked when some older entry is also ready
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            blocked_c[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready_c[j] && age_q[j][i]) begin
                    blocked_c[i] = 1'b1;
                end
            end
        end
    end

    // Oldest ready entry: the unique ready, unblocked one
    always_comb begin
        sel_valid_c = 1'b0;
        sel_idx_c   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_c[i] && !blocked_c[i]) begin
                sel_valid_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry (downward scan so the lowest index wins)
    always_comb begin
        alloc_idx_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx_c = IDX_W'(i);
            end
        end
    end

    assign full_c       = &busy_q;
    assign disp_fire_c  = disp_valid && !full_c;
    assign issue_fire_c = sel_valid_c && issue_ready;
    assign cdb_live_c   = cdb_valid && (cdb_tag != '0);

    // Next-state: flush wins; otherwise wakeup, issue release and dispatch combine
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            op_d[i]  = op_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
        end

        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_live_c) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i] && (qj_q[i] == cdb_tag)) begin
                        vj_d[i] = cdb_data;
                        qj_d[i] = '0;
                    end
                    if (busy_q[i] && (qk_q[i] == cdb_tag)) begin
                        vk_d[i] = cdb_data;
                        qk_d[i] = '0;
                    end
                end
            end

            if (issue_fire_c) begin
                busy_d[sel_idx_c] = 1'b0;
            end

            if (disp_fire_c) begin
                busy_d[alloc_idx_c] = 1'b1;
                op_d[alloc_idx_c]   = disp_op;
                vj_d[alloc_idx_c]   = disp_vj;
                vk_d[alloc_idx_c]   = disp_vk;
                qj_d[alloc_idx_c]   = disp_qj;
                qk_d[alloc_idx_c]   = disp_qk;
                // Same-cycle CDB bypass into the newly allocated entry
                if (cdb_live_c && (disp_qj == cdb_tag)) begin
                    vj_d[alloc_idx_c] = cdb_data;
                    qj_d[alloc_idx_c] = '0;
                end
                if (cdb_live_c && (disp_qk == cdb_tag)) begin
                    vk_d[alloc_idx_c] = cdb_data;
                    qk_d[alloc_idx_c] = '0;
                end
                // New entry is younger than every other; stale rows of free entries
                // are rewritten when those entries are next allocated
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[alloc_idx_c][j] = 1'b0;
                    age_d[j][alloc_idx_c] = (IDX_W'(j) != alloc_idx_c);
                end
            end

            case ({disp_fire_c, issue_fire_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!nRST) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
                op_q[i]  <= op_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
            end
        end
    end

    // Outputs decoded from registered state; zero when nothing is presented
    assign issue_valid = sel_valid_c;
    assign issue_op    = sel_valid_c ? op_q[sel_idx_c] : '0;
    assign issue_vj    = sel_valid_c ? vj_q[sel_idx_c] : '0;
    assign issue_vk    = sel_valid_c ? vk_q[sel_idx_c] : '0;
    assign issue_tag   = sel_valid_c ? TAG_W'({ID_W'(STATION_ID), sel_idx_c}) : '0;
    assign full        = full_c;
    assign disp_ready  = !full_c;
    assign count       = count_q;

endmodule

// File: tb/tb_res_station_param.sv
// Self-checking bench for res_station_param: directed scenarios with constant
// expectations, then randomized traffic checked against a dispatch-ordered
// queue model of the station.
module tb_res_station_param;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OP_W       = 5;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned STATION_ID = 1;
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              nRST;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic [TAG_W-1:0]  disp_qj;
    logic [TAG_W-1:0]  disp_qk;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_tag;
    logic              full;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    res_station_param #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W),
        .ID_W(ID_W), .STATION_ID(STATION_ID)
    ) dut (
        .clk(clk), .nRST(nRST), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_tag(issue_tag),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: entries kept in dispatch order, plus slot occupancy
    typedef struct {
        int                slot;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } ent_t;

    ent_t mq[$];
    bit   m_busy [DEPTH];

    // Position in mq of the oldest entry with both operands present, -1 if none
    function automatic int m_pick();
        for (int p = 0; p < mq.size(); p++) begin
            if (mq[p].qj == '0 && mq[p].qk == '0) return p;
        end
        return -1;
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic m_edge();
        int   p;
        int   slot;
        bit   acc;
        ent_t e;
        if (!nRST || flush) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            return;
        end
        p    = m_pick();
        acc  = disp_valid && (mq.size() < DEPTH);
        slot = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_busy[i] && slot < 0) slot = i;
        end
        if (cdb_valid && cdb_tag != '0) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].qj == cdb_tag) begin mq[k].vj = cdb_data; mq[k].qj = '0; end
                if (mq[k].qk == cdb_tag) begin mq[k].vk = cdb_data; mq[k].qk = '0; end
            end
        end
        if (p >= 0 && issue_ready) begin
            m_busy[mq[p].slot] = 1'b0;
            mq.delete(p);
        end
        if (acc) begin
            e.slot = slot;
            e.op   = disp_op;
            e.vj   = disp_vj;
            e.vk   = disp_vk;
            e.qj   = disp_qj;
            e.qk   = disp_qk;
            if (cdb_valid && cdb_tag != '0 && disp_qj == cdb_tag) begin e.vj = cdb_data; e.qj = '0; end
            if (cdb_valid && cdb_tag != '0 && disp_qk == cdb_tag) begin e.vk = cdb_data; e.qk = '0; end
            m_busy[slot] = 1'b1;
            mq.push_back(e);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [OP_W-1:0] op,
                            input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                            input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk);
        disp_valid = v;
        disp_op    = op;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_vj    = vj;
        disp_vk    = vk;
    endtask

    task automatic set_cdb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic test_reset();
        nRST = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        set_disp(1'b0, '0, '0, '0, '0, '0);
        set_cdb(1'b0, '0, '0);
        tick(); tick();
        nRST = 1'b1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fails++; $display("FAIL rst_issue_valid got=%0h exp=0", issue_valid); end
        n_checks++; if (full !== 1'b0) begin n_fails++; $display("FAIL rst_full got=%0h exp=0", full); end
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fails++; $display("FAIL rst_disp_ready got=%0h exp=1", disp_ready); end
        n_checks++; if (issue_tag !== 4'd0 || issue_op !== 5'd0) begin n_fails++; $display("FAIL rst_outputs tag=%0h op=%0h exp 0/0", issue_tag, issue_op); end
    endtask

    task automatic test_basic_issue();
        issue_ready = 1'b1;
        set_disp(1'b1, 5'd3, 4'd0, 4'd0, 32'd5, 32'd7);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (issue_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid got=%0h exp=1", issue_valid); end
        n_checks++; if (issue_op !== 5'd3) begin n_fails++; $display("FAIL basic_op got=%0d exp=3", issue_op); end
        n_checks++; if (issue_vj !== 32'd5 || issue_vk !== 32'd7) begin n_fails++; $display("FAIL basic_operands vj=%0d vk=%0d exp 5/7", issue_vj, issue_vk); end
        n_checks++; if (issue_tag !== 4'd4) begin n_fails++; $display("FAIL basic_tag got=%0d exp=4", issue_tag); end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL basic_count_after got=%0d exp=0", count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fails++; $display("FAIL basic_drained got=%0h exp=0", issue_valid); end
        issue_ready = 1'b0;
    endtask

    task automatic test_wakeup_order();
        issue_ready = 1'b0;
        set_disp(1'b1, 5'd1, 4'd9, 4'd0, 32'd0, 32'h10);
        tick();
        set_disp(1'b1, 5'd2, 4'd0, 4'd0, 32'h20, 32'h21);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (issue_op !== 5'd2 || issue_tag !== 4'd5) begin n_fails++; $display("FAIL wake_b_first op=%0d tag=%0d exp 2/5", issue_op, issue_tag); end
        set_cdb(1'b1, 4'd9, 32'hAA);
        tick();
        set_cdb(1'b0, '0, '0);
        n_checks++; if (issue_op !== 5'd1 || issue_tag !== 4'd4) begin n_fails++; $display("FAIL wake_a_older op=%0d tag=%0d exp 1/4", issue_op, issue_tag); end
        n_checks++; if (issue_vj !== 32'hAA) begin n_fails++; $display("FAIL wake_a_vj got=%0h exp=aa", issue_vj); end
        issue_ready = 1'b1;
        tick();
        n_checks++; if (issue_op !== 5'd2 || count !== 3'd1) begin n_fails++; $display("FAIL wake_b_after op=%0d count=%0d exp 2/1", issue_op, count); end
        tick();
        issue_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin n_fails++; $display("FAIL wake_drain count=%0d valid=%0h exp 0/0", count, issue_valid); end
    endtask

    task automatic test_full();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, OP_W'(10 + i), 4'd6, 4'd0, '0, DATA_W'(i));
            tick();
        end
        n_checks++; if (full !== 1'b1 || disp_ready !== 1'b0) begin n_fails++; $display("FAIL full_flags full=%0h ready=%0h exp 1/0", full, disp_ready); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fails++; $display("FAIL full_none_ready got=%0h exp=0", issue_valid); end
        set_disp(1'b1, 5'd31, 4'd0, 4'd0, 32'd1, 32'd1);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (count !== 3'd4) begin n_fails++; $display("FAIL full_fifth_ignored count=%0d exp=4", count); end
        set_cdb(1'b1, 4'd6, 32'h66);
        tick();
        set_cdb(1'b0, '0, '0);
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (issue_valid !== 1'b1 || issue_op !== OP_W'(10 + i) || issue_vj !== 32'h66) begin n_fails++; $display("FAIL full_issue_%0d valid=%0h op=%0d vj=%0h exp 1/%0d/66", i, issue_valid, issue_op, issue_vj, 10 + i); end
            tick();
        end
        issue_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL full_drained count=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        issue_ready = 1'b0;
        set_disp(1'b1, 5'd4, 4'd5, 4'd5, 32'd0, 32'd0);
        set_cdb(1'b1, 4'd5, 32'h11);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        set_cdb(1'b0, '0, '0);
        n_checks++; if (issue_valid !== 1'b1 || issue_op !== 5'd4) begin n_fails++; $display("FAIL bypass_ready valid=%0h op=%0d exp 1/4", issue_valid, issue_op); end
        n_checks++; if (issue_vj !== 32'h11 || issue_vk !== 32'h11) begin n_fails++; $display("FAIL bypass_values vj=%0h vk=%0h exp 11/11", issue_vj, issue_vk); end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL bypass_drain count=%0d exp=0", count); end
    endtask

    task automatic test_full_issue_dispatch();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, OP_W'(20 + i), 4'd0, 4'd0, DATA_W'(i), DATA_W'(i));
            tick();
        end
        n_checks++; if (full !== 1'b1 || issue_op !== 5'd20) begin n_fails++; $display("FAIL fid_setup full=%0h op=%0d exp 1/20", full, issue_op); end
        issue_ready = 1'b1;
        set_disp(1'b1, 5'd30, 4'd0, 4'd0, 32'd9, 32'd9);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (count !== 3'd3 || disp_ready !== 1'b1) begin n_fails++; $display("FAIL fid_rejected count=%0d ready=%0h exp 3/1", count, disp_ready); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (issue_op !== OP_W'(20 + i)) begin n_fails++; $display("FAIL fid_order_%0d op=%0d exp=%0d", i, issue_op, 20 + i); end
            tick();
        end
        issue_ready = 1'b0;
        n_checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin n_fails++; $display("FAIL fid_drain count=%0d valid=%0h exp 0/0", count, issue_valid); end
    endtask

    // Slot 0 is reused by a younger op while slot 1 holds an older waiting op
    task automatic test_age_not_index();
        issue_ready = 1'b0;
        set_disp(1'b1, 5'd7, 4'd0, 4'd0, 32'd1, 32'd1);
        tick();
        set_disp(1'b1, 5'd8, 4'd8, 4'd0, 32'd0, 32'd2);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        set_disp(1'b1, 5'd9, 4'd0, 4'd0, 32'd3, 32'd3);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (issue_op !== 5'd9 || issue_tag !== 4'd4) begin n_fails++; $display("FAIL age_young_only op=%0d tag=%0d exp 9/4", issue_op, issue_tag); end
        set_cdb(1'b1, 4'd8, 32'h88);
        tick();
        set_cdb(1'b0, '0, '0);
        n_checks++; if (issue_op !== 5'd8 || issue_tag !== 4'd5 || issue_vj !== 32'h88) begin n_fails++; $display("FAIL age_older_wins op=%0d tag=%0d vj=%0h exp 8/5/88", issue_op, issue_tag, issue_vj); end
        issue_ready = 1'b1;
        tick(); tick();
        issue_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fails++; $display("FAIL age_drain count=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, OP_W'(i + 1), 4'd0, 4'd0, '0, '0);
            tick();
        end
        n_checks++; if (count !== 3'd3) begin n_fails++; $display("FAIL flush_setup count=%0d exp=3", count); end
        flush = 1'b1; issue_ready = 1'b1;
        set_disp(1'b1, 5'd15, 4'd0, 4'd0, '0, '0);
        tick();
        flush = 1'b0; issue_ready = 1'b0;
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin n_fails++; $display("FAIL flush_clear count=%0d valid=%0h exp 0/0", count, issue_valid); end
        n_checks++; if (disp_ready !== 1'b1 || full !== 1'b0) begin n_fails++; $display("FAIL flush_flags ready=%0h full=%0h exp 1/0", disp_ready, full); end
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        set_disp(1'b1, 5'd12, 4'd0, 4'd0, 32'hC, 32'hD);
        tick();
        set_disp(1'b0, '0, '0, '0, '0, '0);
        n_checks++; if (issue_valid !== 1'b1) begin n_fails++; $display("FAIL rmid_setup valid=%0h exp=1", issue_valid); end
        nRST = 1'b0; issue_ready = 1'b1;
        tick();
        nRST = 1'b1; issue_ready = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin n_fails++; $display("FAIL rmid_state valid=%0h count=%0d exp 0/0", issue_valid, count); end
        n_checks++; if (issue_op !== 5'd0 || issue_vj !== 32'd0 || issue_vk !== 32'd0 || issue_tag !== 4'd0) begin n_fails++; $display("FAIL rmid_outputs op=%0h vj=%0h vk=%0h tag=%0h exp 0", issue_op, issue_vj, issue_vk, issue_tag); end
    endtask

    task automatic test_random();
        int                p;
        logic              e_valid;
        logic [OP_W-1:0]   e_op;
        logic [DATA_W-1:0] e_vj;
        logic [DATA_W-1:0] e_vk;
        logic [TAG_W-1:0]  e_tag;
        for (int c = 0; c < 800; c++) begin
            p       = m_pick();
            e_valid = (p >= 0);
            e_op    = (p >= 0) ? mq[p].op : '0;
            e_vj    = (p >= 0) ? mq[p].vj : '0;
            e_vk    = (p >= 0) ? mq[p].vk : '0;
            e_tag   = (p >= 0) ? TAG_W'(STATION_ID * (1 << $clog2(DEPTH)) + mq[p].slot) : '0;
            n_checks++; if (issue_valid !== e_valid) begin n_fails++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, issue_valid, e_valid); end
            n_checks++; if (issue_op !== e_op) begin n_fails++; $display("FAIL rnd_op c=%0d got=%0h exp=%0h", c, issue_op, e_op); end
            n_checks++; if (issue_vj !== e_vj) begin n_fails++; $display("FAIL rnd_vj c=%0d got=%0h exp=%0h", c, issue_vj, e_vj); end
            n_checks++; if (issue_vk !== e_vk) begin n_fails++; $display("FAIL rnd_vk c=%0d got=%0h exp=%0h", c, issue_vk, e_vk); end
            n_checks++; if (issue_tag !== e_tag) begin n_fails++; $display("FAIL rnd_tag c=%0d got=%0h exp=%0h", c, issue_tag, e_tag); end
            n_checks++; if (count !== CNT_W'(mq.size())) begin n_fails++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            n_checks++; if (full !== (mq.size() == DEPTH) || disp_ready !== (mq.size() != DEPTH)) begin n_fails++; $display("FAIL rnd_flags c=%0d full=%0h ready=%0h size=%0d", c, full, disp_ready, mq.size()); end

            nRST        = ($urandom_range(0, 149) != 0);
            flush       = ($urandom_range(0, 59) == 0);
            issue_ready = ($urandom_range(0, 9) < 6);
            set_disp($urandom_range(0, 9) < 6, OP_W'($urandom),
                     ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 6)) : '0,
                     ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 6)) : '0,
                     DATA_W'($urandom), DATA_W'($urandom));
            set_cdb($urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 6)), DATA_W'($urandom));
            tick();
        end
        nRST = 1'b1; flush = 1'b0; issue_ready = 1'b0;
        set_disp(1'b0, '0, '0, '0, '0, '0);
        set_cdb(1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup_order();
        test_full();
        test_bypass();
        test_full_issue_dispatch();
        test_age_not_index();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/res_station_param.md
Name: res_station_param

Overview:
- Parametrised reservation station for the Tomasulo core: DEPTH entries per functional-unit group.
- Accepts dispatched ops with operand values or producer tags, snoops the CDB for wakeup, and issues the oldest ready entry to its ALU over a valid/ready handshake.
- Sits between the dispatch/rename stage and one functional unit; each instance owns a distinct STATION_ID so the entry tags it issues are globally unique on the CDB.

Parameters:
DEPTH, 4, number of entries (2..16)
DATA_W, 32, operand/CDB data width
OP_W, 5, opcode width
TAG_W, 4, producer-tag width; tag 0 means "value present"; TAG_W >= ID_W + clog2(DEPTH)
ID_W, 2, station-ID field width
STATION_ID, 1, this station's ID, nonzero (keeps issued tags nonzero)

Ports:
clk  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
flush  in  1  synchronous clear of all entries (mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  = !full
disp_op  in  OP_W  opcode
disp_vj / disp_vk  in  DATA_W  operand values
disp_qj / disp_qk  in  TAG_W  operand producer tags, 0 = value valid
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
issue_valid  out  1  a ready entry is presented
issue_ready  in  1  FU accepts
issue_op  out  OP_W  opcode of presented entry
issue_vj / issue_vk  out  DATA_W  operand values
issue_tag  out  TAG_W  {zero pad, STATION_ID, entry index}; result tag the FU broadcasts
full  out  1  all entries busy
count  out  clog2(DEPTH+1)  busy entry count

Behaviour:
- Reset (nRST=0 at edge): all busy=0, age state cleared; hence issue_valid=0, full=0, count=0, disp_ready=1; issue_op/vj/vk/tag drive 0 when issue_valid=0 (no latches).
- Priority at an edge: reset > flush > {issue release, dispatch, wakeup}; the last three apply together.
- Flush: all busy=0 next cycle; same-cycle dispatch and issue are discarded.
- Dispatch: disp_valid & disp_ready allocates the lowest-index free entry and stores op, V, Q. Same-cycle CDB bypass: if cdb_valid and cdb_tag!=0 and cdb_tag==disp_qj, store Vj=cdb_data, Qj=0; Qk likewise, independently.
- disp_ready uses current-cycle state only. A slot freed by this cycle's issue is usable next cycle. Full + issue + dispatch in one cycle -> dispatch not accepted.
- Wakeup: every busy entry with Qj==cdb_tag (cdb_valid, tag!=0) takes Vj=cdb_data, Qj=0; Qk likewise; both operands of one entry may wake together.
- Ready entry: busy & Qj==0 & Qk==0, from registered state. Wakeup-to-issue and dispatch-to-issue latency is therefore 1 cycle minimum.
- Selection: oldest ready entry by dispatch order, tracked by an age matrix or per-entry sequence stamps; never by index. Outputs are combinational from registers.
- Handshake: the presented entry is held stable while issue_valid & !issue_ready, unless an older entry becomes ready. issue_valid & issue_ready frees the entry at the edge; count decrements.
- count tracks busy entries exactly: +1 dispatch, -1 issue, net 0 on both together.
- cdb_tag==0 is ignored. Broadcast of a tag no entry waits on has no effect.

Test Plan:
- Reset then dispatch op=3, qj=qk=0, vj=5, vk=7, issue_ready=1 -> cycle+1: issue_valid=1, op=3, vj=5, vk=7, issue_tag=4 (ID 1, idx 0); cycle+2: count=0.
- Dispatch A(qj=9), then B(ready), issue_ready=0 -> B presented. CDB tag 9 data 0xAA -> next cycle A (older) presented, vj=0xAA; on accept A freed, B presented after.
- Fill 4 entries with qj=6 -> full=1, disp_ready=0. Fifth dispatch ignored. CDB tag 6 -> all ready, issued in dispatch order over 4 accepting cycles.
- Dispatch qj=qk=5 with cdb_valid, tag 5, data 0x11 same cycle -> entry ready; next cycle vj=vk=0x11.
- Full RS, issue accepted and dispatch in the same cycle -> dispatch rejected; next cycle count=3, disp_ready=1.
- Flush with 3 busy plus a concurrent dispatch -> next cycle count=0, issue_valid=0. Reset asserted mid-handshake -> outputs 0 next cycle.
